// File: rtl/half_adder_pipe.sv
// half_adder_pipe: registered lane-wise half adders with carry statistics behind a two-entry skid buffer
module half_adder_pipe #(
    parameter int WIDTH = 1,
    localparam int CW = ($clog2(WIDTH + 1) > 1) ? $clog2(WIDTH + 1) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry,
    output logic [CW-1:0]    carry_count,
    output logic             carry_any
);
    logic [WIDTH-1:0] c_in;
    logic [CW-1:0]    cnt_in;
    logic             skid_full;
    logic [WIDTH-1:0] skid_sum;
    logic [WIDTH-1:0] skid_carry;
    logic [CW-1:0]    skid_cnt;
    logic             skid_any;
    logic             acc;
    logic             drain;
    assign c_in     = a & b;
    assign in_ready = !skid_full && !rst;
    assign acc      = in_valid && in_ready;
    assign drain    = out_valid && out_ready;
    always_comb begin
        cnt_in = '0;
        for (int i = 0; i < WIDTH; i++)
            cnt_in = cnt_in + CW'(c_in[i]);
    end
    // operand data is captured only on an accepted word, so idle X never reaches the outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            sum         <= '0;
            carry       <= '0;
            carry_count <= '0;
            carry_any   <= 1'b0;
            skid_full   <= 1'b0;
            skid_sum    <= '0;
            skid_carry  <= '0;
            skid_cnt    <= '0;
            skid_any    <= 1'b0;
        end else if (drain || !out_valid) begin
            if (skid_full) begin
                out_valid   <= 1'b1;
                sum         <= skid_sum;
                carry       <= skid_carry;
                carry_count <= skid_cnt;
                carry_any   <= skid_any;
                skid_full   <= 1'b0;
            end else begin
                out_valid <= acc;
                if (acc) begin
                    sum         <= a ^ b;
                    carry       <= c_in;
                    carry_count <= cnt_in;
                    carry_any   <= |c_in;
                end
            end
        end else if (acc) begin
            skid_full  <= 1'b1;
            skid_sum   <= a ^ b;
            skid_carry <= c_in;
            skid_cnt   <= cnt_in;
            skid_any   <= |c_in;
        end
    end
endmodule

// File: tb/tb_half_adder_pipe.sv
// tb_half_adder_pipe: directed and random checks of half_adder_pipe at widths 1, 8 and 16
module tb_half_adder_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        v1 = 0, r1, ov1, or1 = 1;
    logic [0:0]  a1 = 0, b1 = 0, s1, c1, n1;
    logic        y1;
    logic        v8 = 0, r8, ov8, or8 = 1;
    logic [7:0]  a8 = 0, b8 = 0, s8, c8;
    logic [3:0]  n8;
    logic        y8;
    logic        v16 = 0, r16, ov16, or16 = 1;
    logic [15:0] a16 = 0, b16 = 0, s16, c16;
    logic [4:0]  n16;
    logic        y16;

    half_adder_pipe #(.WIDTH(1)) u1 (.clk(clk), .rst(rst), .in_valid(v1), .in_ready(r1), .a(a1), .b(b1),
        .out_valid(ov1), .out_ready(or1), .sum(s1), .carry(c1), .carry_count(n1), .carry_any(y1));
    half_adder_pipe #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .in_valid(v8), .in_ready(r8), .a(a8), .b(b8),
        .out_valid(ov8), .out_ready(or8), .sum(s8), .carry(c8), .carry_count(n8), .carry_any(y8));
    half_adder_pipe #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .in_valid(v16), .in_ready(r16), .a(a16), .b(b16),
        .out_valid(ov16), .out_ready(or16), .sum(s16), .carry(c16), .carry_count(n16), .carry_any(y16));

    int total = 0;
    int passed = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk8(input string tag, input logic [7:0] s, input logic [7:0] c, input logic [3:0] n, input logic y);
        chk({tag, " out_valid"}, 64'(ov8), 64'(1));
        chk({tag, " fields"}, 64'({s8, c8, n8, y8}), 64'({s, c, n, y}));
    endtask

    logic [37:0] q[$];
    logic [37:0] held;
    logic        stalled;
    logic [15:0] ca;

    initial begin
        step();
        step();
        chk("reset in_ready low", 64'({r1, r8, r16}), 64'(0));
        chk("reset out_valid", 64'({ov1, ov8, ov16}), 64'(0));
        chk("reset fields w8", 64'({s8, c8, n8, y8}), 64'(0));
        chk("reset fields w16", 64'({s16, c16, n16, y16}), 64'(0));
        rst = 1'b0;
        #1;
        chk("in_ready after reset", 64'({r1, r8, r16}), 64'(3'b111));

        // width 1: one word every 10 cycles
        for (int i = 0; i < 4; i++) begin
            v1 = 1'b1;
            a1 = 1'(i >> 1);
            b1 = 1'(i);
            step();
            v1 = 1'b0;
            chk("w1 out_valid", 64'(ov1), 64'(1));
            chk("w1 sum", 64'(s1), 64'(i == 1 || i == 2));
            chk("w1 carry/count/any", 64'({c1, n1, y1}), (i == 3) ? 64'(3'b111) : 64'(0));
            repeat (9) step();
            chk("w1 idle", 64'(ov1), 64'(0));
        end

        // width 8 back-to-back
        v8 = 1; a8 = 8'hFF; b8 = 8'h01;
        step();
        chk8("w8 ff+01", 8'hFE, 8'h01, 4'd1, 1'b1);
        a8 = 8'hFF; b8 = 8'hFF;
        step();
        chk8("w8 ff+ff", 8'h00, 8'hFF, 4'd8, 1'b1);
        a8 = 8'hA5; b8 = 8'h5A;
        step();
        chk8("w8 a5+5a", 8'hFF, 8'h00, 4'd0, 1'b0);
        v8 = 0;
        step();
        chk("w8 drained", 64'(ov8), 64'(0));

        // backpressure
        or8 = 0; v8 = 1; b8 = 8'h03; a8 = 8'h01;
        step();
        chk8("bp first", 8'h02, 8'h01, 4'd1, 1'b1);
        chk("bp ready one entry", 64'(r8), 64'(1));
        a8 = 8'h02;
        step();
        chk("bp full in_ready", 64'(r8), 64'(0));
        chk8("bp hold 1", 8'h02, 8'h01, 4'd1, 1'b1);
        a8 = 8'h03;
        step();
        chk("bp still full", 64'(r8), 64'(0));
        chk8("bp hold 2", 8'h02, 8'h01, 4'd1, 1'b1);
        or8 = 1;
        step();
        chk8("bp word2", 8'h01, 8'h02, 4'd1, 1'b1);
        chk("bp ready returns", 64'(r8), 64'(1));
        step();
        chk8("bp word3", 8'h00, 8'h03, 4'd2, 1'b1);
        a8 = 8'h04;
        step();
        chk8("bp word4", 8'h07, 8'h00, 4'd0, 1'b0);
        v8 = 0;
        step();
        chk("bp no extra", 64'(ov8), 64'(0));

        // reset with both entries full
        or8 = 0; v8 = 1; a8 = 8'h11; b8 = 8'h33;
        step();
        a8 = 8'h22;
        step();
        chk("mid full", 64'(r8), 64'(0));
        rst = 1;
        step();
        chk("mid rst out_valid", 64'(ov8), 64'(0));
        chk("mid rst fields", 64'({s8, c8, n8, y8}), 64'(0));
        chk("mid rst in_ready", 64'(r8), 64'(0));
        rst = 0; v8 = 0; or8 = 1;
        #1;
        chk("mid in_ready after", 64'(r8), 64'(1));
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mid no stale", 64'(ov8), 64'(0));
        end

        // random soak, width 16
        stalled = 1'b0;
        held = '0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            if (stalled) begin
                chk("soak stall valid", 64'(ov16), 64'(1));
                chk("soak stall stable", 64'({s16, c16, n16, y16}), 64'(held));
            end
            v16 = ($urandom_range(0, 3) != 0);
            a16 = v16 ? 16'($urandom) : 'x;
            b16 = v16 ? 16'($urandom) : 'x;
            or16 = ($urandom_range(0, 2) != 0);
            #1;
            if (ov16 && or16) begin
                if (q.size() == 0) chk("soak unexpected word", 64'(1), 64'(0));
                else chk("soak word", 64'({s16, c16, n16, y16}), 64'(q.pop_front()));
            end
            if (v16 && r16) begin
                ca = a16 & b16;
                q.push_back({a16 ^ b16, ca, 5'($countones(ca)), |ca});
            end
            stalled = ov16 && !or16;
            held = {s16, c16, n16, y16};
            step();
        end
        v16 = 0; or16 = 1;
        for (int i = 0; i < 10 && q.size() > 0; i++) begin
            #1;
            if (ov16) chk("soak drain word", 64'({s16, c16, n16, y16}), 64'(q.pop_front()));
            step();
        end
        chk("soak queue empty", 64'(q.size()), 64'(0));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/half_adder_pipe.md
# half_adder_pipe

Registered, parameterizable array of independent half adders with a valid/ready stream interface. Each lane produces sum = a XOR b and carry = a AND b. The block also reports per-word carry statistics. It sits in the datapath as a leaf arithmetic primitive feeding adder trees and ALU stages, and absorbs downstream backpressure through a skid buffer.

## Interface
- WIDTH, default 1: number of independent 1-bit half-adder lanes (≥1).
- CW, derived = max(1, clog2(WIDTH+1)): width of carry_count; not user-overridable.

- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- in_valid  in  1  a/b carry a valid word.
- in_ready  out  1  block accepts a word this cycle.
- a  in  WIDTH  operand A, lane i = bit i.
- b  in  WIDTH  operand B, lane i = bit i.
- out_valid  out  1  sum/carry/carry_count/carry_any valid.
- out_ready  in  1  downstream accepts the output word.
- sum  out  WIDTH  lane-wise a XOR b.
- carry  out  WIDTH  lane-wise a AND b.
- carry_count  out  CW  number of set bits in carry.
- carry_any  out  1  OR-reduction of carry.

## Operation
- Input transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
- Per accepted word: sum = a ^ b, carry = a & b, carry_count = popcount(a & b) zero-extended to CW, carry_any = |(a & b).
- Lanes are fully independent. There is no carry propagation between lanes.
- Storage: one output register plus one skid register (2 entries total).
  - If the output register is empty or drains this cycle, an accepted word loads directly into it.
  - Otherwise the word loads into the skid register. When the output drains, the skid word moves into the output register.
- in_ready = !skid_full && !rst. The skid flag is registered, so in_ready has no combinational path from out_ready.
- Outputs hold stable while out_valid && !out_ready. No output field changes until the transfer completes.
- Words leave in acceptance order. No word is dropped or duplicated.
- Inputs are ignored when in_ready is low.
- X on a/b while in_valid is low must not propagate to the outputs.

## Timing
- Reset: with rst high at a clock edge, on the next cycle:
  - out_valid = 0, skid empty.
  - sum = 0, carry = 0, carry_count = 0, carry_any = 0.
  - in_ready is low while rst is high and 1 in the first cycle after rst deasserts.
- Latency: a word accepted at edge N appears on the outputs with out_valid = 1 after edge N (visible in cycle N+1), provided the output register was empty or draining.
- Throughput: 1 word per cycle with out_ready held high.
- Full: both entries occupied → in_ready = 0 the next cycle. It returns to 1 the cycle after an output transfer frees the skid.
- Simultaneous input and output transfer with one entry occupied: the new word replaces the output contents. Occupancy stays at 1.
- Reset mid-operation: all in-flight words are discarded. No output transfer is reported in the reset cycle.

## Test plan
- WIDTH=1, one word every 10 cycles with out_ready=1. Required output one cycle after each input:
  - a,b = 0,0 → sum 0, carry 0.
  - a,b = 0,1 → sum 1, carry 0.
  - a,b = 1,0 → sum 1, carry 0.
  - a,b = 1,1 → sum 0, carry 1, carry_count 1, carry_any 1.
- WIDTH=8, out_ready=1:
  - a=0xFF, b=0x01 → sum 0xFE, carry 0x01, count 1, any 1.
  - a=0xFF, b=0xFF → sum 0x00, carry 0xFF, count 8.
  - a=0xA5, b=0x5A → sum 0xFF, carry 0x00, count 0, any 0.
- Backpressure, WIDTH=8: stream 0x01..0x04 as a with b=0x03, and hold out_ready=0.
  - After 2 accepts, in_ready=0 and the outputs stay at the first word.
  - Release out_ready: all 4 words emerge in order (sums 0x02, 0x01, 0x00, 0x07) with no loss.
- Reset mid-stream: assert rst for 1 cycle with both entries full.
  - Next cycle: out_valid=0, all output fields 0, in_ready=1 after deassert.
  - No stale word appears afterwards.
- Random soak, WIDTH=16, 10k cycles, random in_valid/out_ready:
  - A scoreboard matches every output word against a^b, a&b and the popcount.
  - Check that outputs are stable while stalled.
